bp_fe_mock_be: RTL and testbench

- Parametrised mock backend that replaces the tied-off FE command/queue stub in FE-level benches.
- Boots the FE with a state-reset command and consumes fe_queue entries with configurable backpressure.
- Checks the fetched PC stream against a sequential model and periodically injects PC redirects.
- Reports done/fail status plus counters so an FE + memory bench becomes self-checking.

---
 rtl/bp_fe_mock_be_if.sv | 26 ++
 rtl/bp_fe_mock_be.sv | 184 ++++++++++++++++++
 tb/tb_bp_fe_mock_be.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_mock_be_if.sv
// FE <-> mock backend handshake bundle: fe_queue entries toward the backend, fe_cmd toward the FE.
// master = FE side, slave = mock backend.
interface bp_fe_mock_be_if #(
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32
);
   logic                     fe_queue_v_i;
   logic [vaddr_width_p-1:0] fe_queue_pc_i;
   logic [instr_width_p-1:0] fe_queue_instr_i;
   logic                     fe_queue_exc_i;
   logic                     fe_queue_ready_o;
   logic                     fe_cmd_v_o;
   logic [1:0]               fe_cmd_opcode_o;
   logic [vaddr_width_p-1:0] fe_cmd_pc_o;
   logic                     fe_cmd_yumi_i;

   modport master (
      output fe_queue_v_i, fe_queue_pc_i, fe_queue_instr_i, fe_queue_exc_i, fe_cmd_yumi_i,
      input  fe_queue_ready_o, fe_cmd_v_o, fe_cmd_opcode_o, fe_cmd_pc_o
   );

   modport slave (
      input  fe_queue_v_i, fe_queue_pc_i, fe_queue_instr_i, fe_queue_exc_i, fe_cmd_yumi_i,
      output fe_queue_ready_o, fe_cmd_v_o, fe_cmd_opcode_o, fe_cmd_pc_o
   );
endinterface

// File: rtl/bp_fe_mock_be.sv
// Mock backend: boots the FE, checks the fetched PC stream, injects periodic redirects.
// Optional random backpressure is enabled with `define BP_FE_MOCK_BE_STALL_EN.
module bp_fe_mock_be #(
   parameter int                       vaddr_width_p     = 39,
   parameter int                       instr_width_p     = 32,
   parameter logic [vaddr_width_p-1:0] boot_pc_p         = 'h80000000,
   parameter int                       max_instr_p       = 1024,
   parameter int                       redirect_period_p = 64,
   parameter logic [vaddr_width_p-1:0] redirect_stride_p = 'h100,
   parameter int                       flush_limit_p     = 16,
   parameter int                       cnt_width_p       = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   bp_fe_mock_be_if.slave           fe,
   output logic                     done_o,
   output logic                     fail_o,
   output logic [1:0]               fail_cause_o,
   output logic [vaddr_width_p-1:0] fail_pc_o,
   output logic [cnt_width_p-1:0]   instr_cnt_o,
   output logic [cnt_width_p-1:0]   redirect_cnt_o
);

   typedef logic [vaddr_width_p-1:0] vaddr_t;
   typedef logic [cnt_width_p-1:0]   cnt_t;

   typedef enum logic [2:0] {BOOT, RUN, REDIR, FLUSH, DONE, FAIL} state_e;
   typedef enum logic [1:0] {CAUSE_NONE, CAUSE_EXC, CAUSE_PC, CAUSE_FLUSH} cause_e;

   localparam logic [1:0] opc_state_reset = 2'd1;
   localparam logic [1:0] opc_pc_redirect = 2'd2;

   state_e                   state, state_n;
   cause_e                   cause, cause_n;
   vaddr_t                   exp_pc, exp_pc_n;
   vaddr_t                   fail_pc, fail_pc_n;
   vaddr_t                   redirect_pc;
   cnt_t                     instr_cnt, instr_cnt_n;
   cnt_t                     redirect_cnt, redirect_cnt_n;
   cnt_t                     flush_cnt, flush_cnt_n;
   cnt_t                     period_cnt, period_cnt_n;
   logic [instr_width_p-1:0] last_instr;
   logic                     state_ready, stall_ok, accept, yumi, in_order;
   logic                     cmd_v;
   logic [1:0]               cmd_op;
   vaddr_t                   cmd_pc;

   function automatic cnt_t sat_inc(input cnt_t v);
      return (&v) ? v : v + cnt_t'(1);
   endfunction

`ifdef BP_FE_MOCK_BE_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) lfsr <= 16'hACE1;
      else            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall_ok = (lfsr[1:0] != 2'b00);
`else
   assign stall_ok = 1'b1;
`endif

   assign redirect_pc = exp_pc + redirect_stride_p;
   assign state_ready = (state == RUN) || (state == FLUSH);
   assign cmd_v       = (state == BOOT) || (state == REDIR);
   assign cmd_op      = (state == BOOT) ? opc_state_reset : opc_pc_redirect;
   assign cmd_pc      = (state == BOOT) ? boot_pc_p : redirect_pc;

   // Command/ready outputs are forced low while reset is held, not just after the next edge.
   assign fe.fe_queue_ready_o = reset_n_i & state_ready & stall_ok;
   assign fe.fe_cmd_v_o       = reset_n_i & cmd_v;
   assign fe.fe_cmd_opcode_o  = reset_n_i ? cmd_op : 2'b00;
   assign fe.fe_cmd_pc_o      = reset_n_i ? cmd_pc : '0;

   assign accept = fe.fe_queue_v_i & fe.fe_queue_ready_o;
   assign yumi   = fe.fe_cmd_yumi_i & cmd_v;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_n        = state;
      cause_n        = cause;
      exp_pc_n       = exp_pc;
      fail_pc_n      = fail_pc;
      instr_cnt_n    = instr_cnt;
      redirect_cnt_n = redirect_cnt;
      flush_cnt_n    = flush_cnt;
      period_cnt_n   = period_cnt;
      in_order       = 1'b0;

      case (state)
         BOOT: if (yumi) state_n = RUN;
         RUN: begin
            if (accept) begin
               if (fe.fe_queue_exc_i) begin
                  state_n   = FAIL;
                  cause_n   = CAUSE_EXC;
                  fail_pc_n = fe.fe_queue_pc_i;
               end else if (fe.fe_queue_pc_i != exp_pc) begin
                  state_n   = FAIL;
                  cause_n   = CAUSE_PC;
                  fail_pc_n = fe.fe_queue_pc_i;
               end else begin
                  in_order = 1'b1;
               end
            end
         end
         REDIR: begin
            if (yumi) begin
               exp_pc_n       = redirect_pc;
               redirect_cnt_n = sat_inc(redirect_cnt);
               flush_cnt_n    = '0;
               state_n        = FLUSH;
            end
         end
         FLUSH: begin
            if (accept) begin
               if (!fe.fe_queue_exc_i && (fe.fe_queue_pc_i == exp_pc)) begin
                  in_order = 1'b1;
               end else begin
                  flush_cnt_n = sat_inc(flush_cnt);
                  if (flush_cnt_n > cnt_t'(flush_limit_p)) begin
                     state_n   = FAIL;
                     cause_n   = CAUSE_FLUSH;
                     fail_pc_n = fe.fe_queue_pc_i;
                  end
               end
            end
         end
         default: ;
      endcase

      // An in-order entry: DONE wins over a due redirect on the same entry.
      if (in_order) begin
         instr_cnt_n = sat_inc(instr_cnt);
         exp_pc_n    = exp_pc + vaddr_t'(4);
         state_n     = RUN;
         if (instr_cnt_n == cnt_t'(max_instr_p)) begin
            state_n = DONE;
         end else if (redirect_period_p != 0) begin
            if (period_cnt == cnt_t'(redirect_period_p - 1)) begin
               state_n      = REDIR;
               period_cnt_n = '0;
            end else begin
               period_cnt_n = period_cnt + cnt_t'(1);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state        <= BOOT;
         cause        <= CAUSE_NONE;
         exp_pc       <= boot_pc_p;
         fail_pc      <= '0;
         instr_cnt    <= '0;
         redirect_cnt <= '0;
         flush_cnt    <= '0;
         period_cnt   <= '0;
         last_instr   <= '0;
      end else begin
         state        <= state_n;
         cause        <= cause_n;
         exp_pc       <= exp_pc_n;
         fail_pc      <= fail_pc_n;
         instr_cnt    <= instr_cnt_n;
         redirect_cnt <= redirect_cnt_n;
         flush_cnt    <= flush_cnt_n;
         period_cnt   <= period_cnt_n;
         if (accept) last_instr <= fe.fe_queue_instr_i;
      end
   end

   assign done_o         = (state == DONE);
   assign fail_o         = (state == FAIL);
   assign fail_cause_o   = cause;
   assign fail_pc_o      = fail_pc;
   assign instr_cnt_o    = instr_cnt;
   assign redirect_cnt_o = redirect_cnt;

endmodule

// File: tb/tb_bp_fe_mock_be.sv
// Scoreboard bench for bp_fe_mock_be: three parameterisations share one stimulus driver;
// a negedge monitor pops expected commands and terminal status as the DUT presents them.
module tb_bp_fe_mock_be;

   localparam logic [38:0] BOOT_PC = 39'h80000000;

   typedef struct packed {
      logic [1:0]  op;
      logic [38:0] pc;
   } cmd_exp_t;

   typedef struct packed {
      logic        done;
      logic        fail;
      logic [1:0]  cause;
      logic [38:0] fpc;
      logic [31:0] icnt;
      logic [31:0] rcnt;
   } stat_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic        q_v = 1'b0, q_exc = 1'b0, yumi = 1'b0;
   logic [38:0] q_pc = '0;
   logic [31:0] q_instr = '0;

   int n_vec = 0, n_miss = 0;
   string cur_test = "init";
   cmd_exp_t  cmd_q[$];
   stat_exp_t stat_q[$];
   logic prev_term = 1'b0;

   always #5 clk = ~clk;

   bp_fe_mock_be_if if0 ();
   bp_fe_mock_be_if if1 ();
   bp_fe_mock_be_if if2 ();

   assign if0.fe_queue_v_i = q_v & (sel == 2'd0);
   assign if1.fe_queue_v_i = q_v & (sel == 2'd1);
   assign if2.fe_queue_v_i = q_v & (sel == 2'd2);
   assign if0.fe_cmd_yumi_i = yumi & (sel == 2'd0);
   assign if1.fe_cmd_yumi_i = yumi & (sel == 2'd1);
   assign if2.fe_cmd_yumi_i = yumi & (sel == 2'd2);
   assign if0.fe_queue_pc_i = q_pc;
   assign if1.fe_queue_pc_i = q_pc;
   assign if2.fe_queue_pc_i = q_pc;
   assign if0.fe_queue_exc_i = q_exc;
   assign if1.fe_queue_exc_i = q_exc;
   assign if2.fe_queue_exc_i = q_exc;
   assign if0.fe_queue_instr_i = q_instr;
   assign if1.fe_queue_instr_i = q_instr;
   assign if2.fe_queue_instr_i = q_instr;

   logic        done_w [3];
   logic        fail_w [3];
   logic [1:0]  cause_w[3];
   logic [38:0] fpc_w  [3];
   logic [31:0] icnt_w [3];
   logic [31:0] rcnt_w [3];

   bp_fe_mock_be #(.redirect_period_p(0), .max_instr_p(8)) u_seq (
      .clk_i(clk), .reset_n_i(rst_n), .fe(if0),
      .done_o(done_w[0]), .fail_o(fail_w[0]), .fail_cause_o(cause_w[0]),
      .fail_pc_o(fpc_w[0]), .instr_cnt_o(icnt_w[0]), .redirect_cnt_o(rcnt_w[0]));

   bp_fe_mock_be #(.redirect_period_p(4), .max_instr_p(5)) u_red (
      .clk_i(clk), .reset_n_i(rst_n), .fe(if1),
      .done_o(done_w[1]), .fail_o(fail_w[1]), .fail_cause_o(cause_w[1]),
      .fail_pc_o(fpc_w[1]), .instr_cnt_o(icnt_w[1]), .redirect_cnt_o(rcnt_w[1]));

   bp_fe_mock_be #(.redirect_period_p(4), .flush_limit_p(2)) u_fl (
      .clk_i(clk), .reset_n_i(rst_n), .fe(if2),
      .done_o(done_w[2]), .fail_o(fail_w[2]), .fail_cause_o(cause_w[2]),
      .fail_pc_o(fpc_w[2]), .instr_cnt_o(icnt_w[2]), .redirect_cnt_o(rcnt_w[2]));

   logic        cur_ready, cur_cmd_v, cur_done, cur_fail;
   logic [1:0]  cur_op, cur_cause;
   logic [38:0] cur_cmd_pc, cur_fpc;
   logic [31:0] cur_icnt, cur_rcnt;

   always_comb begin
      cur_ready  = if0.fe_queue_ready_o;
      cur_cmd_v  = if0.fe_cmd_v_o;
      cur_op     = if0.fe_cmd_opcode_o;
      cur_cmd_pc = if0.fe_cmd_pc_o;
      if (sel == 2'd1) begin
         cur_ready  = if1.fe_queue_ready_o;
         cur_cmd_v  = if1.fe_cmd_v_o;
         cur_op     = if1.fe_cmd_opcode_o;
         cur_cmd_pc = if1.fe_cmd_pc_o;
      end else if (sel == 2'd2) begin
         cur_ready  = if2.fe_queue_ready_o;
         cur_cmd_v  = if2.fe_cmd_v_o;
         cur_op     = if2.fe_cmd_opcode_o;
         cur_cmd_pc = if2.fe_cmd_pc_o;
      end
      cur_done  = done_w[sel];
      cur_fail  = fail_w[sel];
      cur_cause = cause_w[sel];
      cur_fpc   = fpc_w[sel];
      cur_icnt  = icnt_w[sel];
      cur_rcnt  = rcnt_w[sel];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s/%s: got 'h%0h, expected 'h%0h", cur_test, name, act, exp);
      end
   endtask

   // Monitor: compare on command handshakes and on the rise of done/fail.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_term <= 1'b0;
      end else begin
         if (cur_cmd_v && yumi) begin
            check("cmd_expected", cmd_q.size() != 0, 1);
            if (cmd_q.size() != 0) begin
               check("cmd_opcode", cur_op, cmd_q[0].op);
               check("cmd_pc", cur_cmd_pc, cmd_q[0].pc);
               void'(cmd_q.pop_front());
            end
         end
         if ((cur_done || cur_fail) && !prev_term) begin
            check("stat_expected", stat_q.size() != 0, 1);
            check("done_fail_excl", cur_done & cur_fail, 0);
            if (stat_q.size() != 0) begin
               check("done", cur_done, stat_q[0].done);
               check("fail", cur_fail, stat_q[0].fail);
               check("fail_cause", cur_cause, stat_q[0].cause);
               check("fail_pc", cur_fpc, stat_q[0].fpc);
               check("instr_cnt", cur_icnt, stat_q[0].icnt);
               check("redirect_cnt", cur_rcnt, stat_q[0].rcnt);
               void'(stat_q.pop_front());
            end
         end
         prev_term <= cur_done | cur_fail;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cmd_v"}, cur_cmd_v, 0);
      check({tag, "_cmd_op"}, cur_op, 0);
      check({tag, "_cmd_pc"}, cur_cmd_pc, 0);
      check({tag, "_ready"}, cur_ready, 0);
      check({tag, "_done"}, cur_done, 0);
      check({tag, "_fail"}, cur_fail, 0);
      check({tag, "_icnt"}, cur_icnt, 0);
      check({tag, "_rcnt"}, cur_rcnt, 0);
   endtask

   task automatic do_reset(input logic [1:0] s);
      rst_n = 1'b0;
      q_v   = 1'b0;
      q_exc = 1'b0;
      yumi  = 1'b0;
      sel   = s;
      #1;
      check_zero("rst");
      repeat (2) cyc();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_cmd();
      int n = 0;
      while (!cur_cmd_v && n < 50) begin
         cyc();
         n++;
      end
      check("cmd_v_wait", cur_cmd_v, 1);
   endtask

   task automatic boot(input int hold);
      cmd_q.push_back('{op: 2'd1, pc: BOOT_PC});
      wait_cmd();
      for (int i = 0; i < hold; i++) begin
         check("boot_v", cur_cmd_v, 1);
         check("boot_op", cur_op, 1);
         check("boot_pc", cur_cmd_pc, BOOT_PC);
         cyc();
      end
      yumi = 1'b1;
      cyc();
      yumi = 1'b0;
      check("boot_v_drop", cur_cmd_v, 0);
`ifndef BP_FE_MOCK_BE_STALL_EN
      check("boot_ready", cur_ready, 1);
`endif
   endtask

   task automatic send(input logic [38:0] pc, input logic exc);
      int n = 0;
      while (!cur_ready && n < 50) begin
         cyc();
         n++;
      end
      check("send_ready", cur_ready, 1);
      q_v     = 1'b1;
      q_pc    = pc;
      q_exc   = exc;
      q_instr = $urandom;
      cyc();
      q_v   = 1'b0;
      q_exc = 1'b0;
   endtask

   task automatic yumi_cmd();
      wait_cmd();
      yumi = 1'b1;
      cyc();
      yumi = 1'b0;
   endtask

   task automatic drain();
      repeat (2) cyc();
      check("cmd_q_drained", cmd_q.size(), 0);
      check("stat_q_drained", stat_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cur_test = "seq";
      do_reset(2'd0);
      boot(5);
      stat_q.push_back('{done: 1'b1, fail: 1'b0, cause: 2'd0, fpc: '0, icnt: 32'd8, rcnt: 32'd0});
      for (int i = 0; i < 8; i++) send(BOOT_PC + 39'(4 * i), 1'b0);
      check("ready_after_done", cur_ready, 0);
      drain();

      cur_test = "mismatch";
      do_reset(2'd0);
      boot(1);
      stat_q.push_back('{done: 1'b0, fail: 1'b1, cause: 2'd2, fpc: 39'h80000008, icnt: 32'd1, rcnt: 32'd0});
      send(39'h80000000, 1'b0);
      send(39'h80000008, 1'b0);
      drain();

      cur_test = "redirect";
      do_reset(2'd1);
      boot(1);
      cmd_q.push_back('{op: 2'd2, pc: 39'h80000110});
      for (int i = 0; i < 4; i++) send(BOOT_PC + 39'(4 * i), 1'b0);
      yumi_cmd();
      stat_q.push_back('{done: 1'b1, fail: 1'b0, cause: 2'd0, fpc: '0, icnt: 32'd5, rcnt: 32'd1});
      send(39'h80000010, 1'b0);
      send(39'h80000014, 1'b0);
      send(39'h80000018, 1'b0);
      send(39'h80000110, 1'b0);
      drain();

      cur_test = "flush_overflow";
      do_reset(2'd2);
      boot(1);
      cmd_q.push_back('{op: 2'd2, pc: 39'h80000110});
      for (int i = 0; i < 4; i++) send(BOOT_PC + 39'(4 * i), 1'b0);
      yumi_cmd();
      stat_q.push_back('{done: 1'b0, fail: 1'b1, cause: 2'd3, fpc: 39'h80000018, icnt: 32'd4, rcnt: 32'd1});
      send(39'h80000010, 1'b0);
      send(39'h80000014, 1'b0);
      send(39'h80000018, 1'b0);
      drain();

      cur_test = "exception";
      do_reset(2'd2);
      boot(1);
      stat_q.push_back('{done: 1'b0, fail: 1'b1, cause: 2'd1, fpc: BOOT_PC, icnt: 32'd0, rcnt: 32'd0});
      send(BOOT_PC, 1'b1);
      drain();

      cur_test = "midrun_reset";
      do_reset(2'd2);
      boot(1);
      for (int i = 0; i < 4; i++) send(BOOT_PC + 39'(4 * i), 1'b0);
      wait_cmd();
      check("redir_op", cur_op, 2);
      check("redir_pc", cur_cmd_pc, 39'h80000110);
      q_v  = 1'b1;
      q_pc = 39'h80000010;
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async");
      repeat (2) cyc();
      q_v = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      boot(1);
      check("post_icnt", cur_icnt, 0);
      check("post_rcnt", cur_rcnt, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
